// File: rtl/bf_pkg.sv
// Shared definitions for the Brainfuck core: opcode bytes and the control-state encoding.
package bf_pkg;

  localparam logic [7:0] OP_RIGHT = 8'h3E;
  localparam logic [7:0] OP_LEFT  = 8'h3C;
  localparam logic [7:0] OP_INC   = 8'h2B;
  localparam logic [7:0] OP_DEC   = 8'h2D;
  localparam logic [7:0] OP_OUT   = 8'h2E;
  localparam logic [7:0] OP_IN    = 8'h2C;
  localparam logic [7:0] OP_JZ    = 8'h5B;
  localparam logic [7:0] OP_JNZ   = 8'h5D;
  localparam logic [7:0] OP_END   = 8'h00;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    SCAN_F_RD,
    SCAN_F_CHK,
    SCAN_B_RD,
    SCAN_B_CHK,
    HALT
  } state_t;

endpackage

// File: rtl/bf_core.sv
// Multi-cycle Brainfuck interpreter: fetches opcodes from a sync ROM, operates on cells
// in a sync RAM, and pulses stdout_en once per '.' instruction.
module bf_core
  import bf_pkg::*;
#(
  parameter int DATA_ADDR_WIDTH  = 16,
  parameter int DATA_VALUE_WIDTH = 32,
  parameter int PROG_ADDR_WIDTH  = 16,
  parameter int PROG_VALUE_WIDTH = 8,
  parameter int DEPTH_WIDTH      = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        en,
  output logic [PROG_ADDR_WIDTH-1:0]  prog_addr,
  output logic                        prog_ren,
  input  logic [PROG_VALUE_WIDTH-1:0] prog_rval,
  output logic [DATA_ADDR_WIDTH-1:0]  data_addr,
  output logic                        data_ren,
  output logic                        data_wen,
  output logic [DATA_VALUE_WIDTH-1:0] data_wval,
  input  logic [DATA_VALUE_WIDTH-1:0] data_rval,
  output logic [7:0]                  stdout,
  output logic                        stdout_en
);

  localparam logic [PROG_VALUE_WIDTH-1:0] P_RIGHT = PROG_VALUE_WIDTH'(OP_RIGHT);
  localparam logic [PROG_VALUE_WIDTH-1:0] P_LEFT  = PROG_VALUE_WIDTH'(OP_LEFT);
  localparam logic [PROG_VALUE_WIDTH-1:0] P_INC   = PROG_VALUE_WIDTH'(OP_INC);
  localparam logic [PROG_VALUE_WIDTH-1:0] P_DEC   = PROG_VALUE_WIDTH'(OP_DEC);
  localparam logic [PROG_VALUE_WIDTH-1:0] P_OUT   = PROG_VALUE_WIDTH'(OP_OUT);
  localparam logic [PROG_VALUE_WIDTH-1:0] P_JZ    = PROG_VALUE_WIDTH'(OP_JZ);
  localparam logic [PROG_VALUE_WIDTH-1:0] P_JNZ   = PROG_VALUE_WIDTH'(OP_JNZ);
  localparam logic [PROG_VALUE_WIDTH-1:0] P_END   = PROG_VALUE_WIDTH'(OP_END);

  localparam logic [PROG_ADDR_WIDTH-1:0]  PC_ONE  = PROG_ADDR_WIDTH'(1);
  localparam logic [DATA_ADDR_WIDTH-1:0]  DP_ONE  = DATA_ADDR_WIDTH'(1);
  localparam logic [DEPTH_WIDTH-1:0]      D_ONE   = DEPTH_WIDTH'(1);
  localparam logic [DATA_VALUE_WIDTH-1:0] V_ONE   = DATA_VALUE_WIDTH'(1);

  state_t                      state_reg, state_next;
  logic [PROG_ADDR_WIDTH-1:0]  pc_reg, pc_next;
  logic [DATA_ADDR_WIDTH-1:0]  dp_reg, dp_next;
  logic [DEPTH_WIDTH-1:0]      depth_reg, depth_next;
  logic [PROG_VALUE_WIDTH-1:0] op_reg, op_next;
  logic [7:0]                  stdout_reg, stdout_next;

  logic rom_rd, ram_rd, ram_wr, out_pulse;
  logic run;

  assign run = en && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= FETCH;
      pc_reg     <= '0;
      dp_reg     <= '0;
      depth_reg  <= '0;
      op_reg     <= '0;
      stdout_reg <= '0;
    end else if (en) begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      dp_reg     <= dp_next;
      depth_reg  <= depth_next;
      op_reg     <= op_next;
      stdout_reg <= stdout_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    dp_next     = dp_reg;
    depth_next  = depth_reg;
    op_next     = op_reg;
    stdout_next = stdout_reg;
    rom_rd      = 1'b0;
    ram_rd      = 1'b0;
    ram_wr      = 1'b0;
    out_pulse   = 1'b0;

    case (state_reg)
      FETCH: begin
        rom_rd     = 1'b1;
        state_next = DECODE;
      end

      DECODE: begin
        case (prog_rval)
          P_RIGHT: begin
            dp_next    = dp_reg + DP_ONE;
            pc_next    = pc_reg + PC_ONE;
            state_next = FETCH;
          end
          P_LEFT: begin
            dp_next    = dp_reg - DP_ONE;
            pc_next    = pc_reg + PC_ONE;
            state_next = FETCH;
          end
          P_END: state_next = HALT;
          P_INC, P_DEC, P_OUT, P_JZ, P_JNZ: begin
            ram_rd     = 1'b1;
            op_next    = prog_rval;
            state_next = EXEC;
          end
          default: begin
            // ',' and comment bytes: no stdin exists, so both just advance
            pc_next    = pc_reg + PC_ONE;
            state_next = FETCH;
          end
        endcase
      end

      EXEC: begin
        pc_next    = pc_reg + PC_ONE;
        state_next = FETCH;
        case (op_reg)
          P_INC, P_DEC: ram_wr = 1'b1;
          P_OUT: begin
            out_pulse   = 1'b1;
            stdout_next = data_rval[7:0];
          end
          P_JZ: begin
            if (data_rval == '0) begin
              depth_next = D_ONE;
              state_next = SCAN_F_RD;
            end
          end
          P_JNZ: begin
            if (data_rval != '0) begin
              // A ']' at address 0 cannot have a matching '[' before it
              if (pc_reg == '0) begin
                pc_next    = pc_reg;
                state_next = HALT;
              end else begin
                depth_next = D_ONE;
                pc_next    = pc_reg - PC_ONE;
                state_next = SCAN_B_RD;
              end
            end
          end
          default: state_next = HALT;
        endcase
      end

      SCAN_F_RD: begin
        rom_rd     = 1'b1;
        state_next = SCAN_F_CHK;
      end

      SCAN_F_CHK: begin
        pc_next    = pc_reg + PC_ONE;
        state_next = SCAN_F_RD;
        case (prog_rval)
          P_JZ: depth_next = depth_reg + D_ONE;
          P_JNZ: begin
            depth_next = depth_reg - D_ONE;
            if (depth_reg == D_ONE) state_next = FETCH;
          end
          P_END: begin
            pc_next    = pc_reg;
            state_next = HALT;
          end
          default: ;
        endcase
      end

      SCAN_B_RD: begin
        rom_rd     = 1'b1;
        state_next = SCAN_B_CHK;
      end

      SCAN_B_CHK: begin
        if (prog_rval == P_JZ && depth_reg == D_ONE) begin
          depth_next = '0;
          pc_next    = pc_reg + PC_ONE;
          state_next = FETCH;
        end else begin
          if (prog_rval == P_JNZ) depth_next = depth_reg + D_ONE;
          else if (prog_rval == P_JZ) depth_next = depth_reg - D_ONE;
          if (pc_reg == '0) begin
            state_next = HALT;
          end else begin
            pc_next    = pc_reg - PC_ONE;
            state_next = SCAN_B_RD;
          end
        end
      end

      HALT: state_next = HALT;

      default: state_next = HALT;
    endcase
  end

  assign prog_addr = pc_reg;
  assign data_addr = dp_reg;
  assign prog_ren  = run && rom_rd;
  assign data_ren  = run && ram_rd;
  assign data_wen  = run && ram_wr;
  assign stdout_en = run && out_pulse;
  assign data_wval = (op_reg == P_DEC) ? (data_rval - V_ONE) : (data_rval + V_ONE);
  // Present the new byte during the strobe itself so the consumer can latch it with the pulse
  assign stdout    = stdout_en ? data_rval[7:0] : stdout_reg;

endmodule

// File: tb/tb_bf_core.sv
// Scoreboarded bench for bf_core: behavioural ROM/RAM, expected output bytes queued per program.
module tb_bf_core;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b1;
  logic [15:0] prog_addr;
  logic        prog_ren;
  logic [7:0]  prog_rval = '0;
  logic [15:0] data_addr;
  logic        data_ren;
  logic        data_wen;
  logic [31:0] data_wval;
  logic [31:0] data_rval = '0;
  logic [7:0]  stdout;
  logic        stdout_en;

  logic [7:0]  rom [0:255];
  logic [31:0] ram [0:511];

  logic [7:0]  exp_q [$];
  logic [7:0]  exp_b;
  int          n_cmp = 0;
  int          n_err = 0;
  int          pulses = 0;
  logic [15:0] last_waddr = '0;

  bf_core dut (
    .clk(clk), .reset(reset), .en(en),
    .prog_addr(prog_addr), .prog_ren(prog_ren), .prog_rval(prog_rval),
    .data_addr(data_addr), .data_ren(data_ren), .data_wen(data_wen),
    .data_wval(data_wval), .data_rval(data_rval),
    .stdout(stdout), .stdout_en(stdout_en)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (prog_ren) prog_rval <= rom[prog_addr[7:0]];
    if (data_ren) data_rval <= ram[data_addr[8:0]];
    if (data_wen) ram[data_addr[8:0]] <= data_wval;
  end

  always @(negedge clk) begin
    if (data_wen) last_waddr = data_addr;
    if (stdout_en) begin
      pulses++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL stdout_unexpected: got %h, expected no pulse", stdout);
      end else begin
        exp_b = exp_q.pop_front();
        if (stdout !== exp_b) begin
          n_err++;
          $display("FAIL stdout_byte: got %h, expected %h", stdout, exp_b);
        end else begin
          $display("out byte %h", stdout);
        end
      end
    end
  end

  task automatic load_prog(input string s);
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    for (int i = 0; i < s.len(); i++) rom[i] = s[i];
    for (int i = 0; i < 512; i++) ram[i] = '0;
    exp_q.delete();
    pulses = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    en = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_halt(output bit ok);
    int idle = 0;
    int cyc = 0;
    while (idle < 8 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (prog_ren || data_ren || data_wen) idle = 0;
      else idle++;
    end
    ok = (idle >= 8);
  endtask

  task automatic check_common(input string name, input int exp_pulses);
    n_cmp++;
    if (pulses !== exp_pulses) begin
      n_err++;
      $display("FAIL %s_pulses: got %0d, expected %0d", name, pulses, exp_pulses);
    end
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL %s_missing_out: got %0d bytes left, expected 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    load_prog("+++.");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({prog_ren, data_ren, data_wen, stdout_en} !== 4'b0000 || stdout !== 8'h00) begin
      n_err++;
      $display("FAIL reset_hold: got strobes %b stdout %h, expected 0000 00",
               {prog_ren, data_ren, data_wen, stdout_en}, stdout);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (prog_ren !== 1'b1 || prog_addr !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_fetch: got ren %b addr %h, expected 1 0000", prog_ren, prog_addr);
    end
    $display("reset checked");
  endtask

  task automatic test_add();
    bit ok;
    int ren_seen = 0;
    load_prog("+++.");
    exp_q.push_back(8'h03);
    do_reset();
    wait_halt(ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL add_halt: got running, expected halt"); end
    check_common("add", 1);
    n_cmp++;
    if (ram[0] !== 32'd3) begin n_err++; $display("FAIL add_cell0: got %h, expected 3", ram[0]); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (prog_ren) ren_seen++;
    end
    n_cmp++;
    if (ren_seen !== 0) begin n_err++; $display("FAIL add_sticky_halt: got %0d fetches, expected 0", ren_seen); end
    $display("add program done cell0=%h", ram[0]);
  endtask

  task automatic test_loop();
    bit ok;
    load_prog("++++++++[>++++++++<-]>+.");
    exp_q.push_back(8'h41);
    do_reset();
    wait_halt(ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL loop_halt: got running, expected halt"); end
    check_common("loop", 1);
    n_cmp++;
    if (ram[0] !== 32'd0 || ram[1] !== 32'd65) begin
      n_err++;
      $display("FAIL loop_cells: got %h %h, expected 0 41", ram[0], ram[1]);
    end
    $display("loop program done cell1=%h", ram[1]);
  endtask

  task automatic test_skip();
    bit ok;
    load_prog("[+.].");
    exp_q.push_back(8'h00);
    do_reset();
    wait_halt(ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL skip_halt: got running, expected halt"); end
    check_common("skip", 1);
    n_cmp++;
    if (ram[0] !== 32'd0) begin n_err++; $display("FAIL skip_cell0: got %h, expected 0", ram[0]); end
    $display("skip program done");
  endtask

  task automatic test_wrap();
    bit ok;
    load_prog("-.<+");
    exp_q.push_back(8'hFF);
    do_reset();
    wait_halt(ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL wrap_halt: got running, expected halt"); end
    check_common("wrap", 1);
    n_cmp++;
    if (ram[0] !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL wrap_cell0: got %h, expected ffffffff", ram[0]); end
    n_cmp++;
    if (last_waddr !== 16'hFFFF || ram[511] !== 32'd1) begin
      n_err++;
      $display("FAIL wrap_dp: got addr %h cell %h, expected ffff 1", last_waddr, ram[511]);
    end
    $display("wrap program done last write addr=%h", last_waddr);
  endtask

  task automatic test_stall();
    bit ok;
    int cyc = 0;
    int strobes = 0;
    load_prog("+.");
    exp_q.push_back(8'h01);
    do_reset();
    while (!data_ren && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (!data_ren) begin n_err++; $display("FAIL stall_decode: got no data read, expected one"); end
    @(posedge clk);
    #1 en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (prog_ren || data_ren || data_wen || stdout_en) strobes++;
    end
    en = 1'b1;
    wait_halt(ok);
    n_cmp++;
    if (strobes !== 0) begin n_err++; $display("FAIL stall_strobes: got %0d active, expected 0", strobes); end
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL stall_halt: got running, expected halt"); end
    check_common("stall", 1);
    n_cmp++;
    if (ram[0] !== 32'd1) begin n_err++; $display("FAIL stall_cell0: got %h, expected 1", ram[0]); end
    $display("stall program done cell0=%h", ram[0]);
  endtask

  task automatic test_reset_scan();
    bit ok;
    int cyc = 0;
    load_prog("+.>[xxxxxxxxxxxx]+.");
    exp_q.push_back(8'h01);
    do_reset();
    while (!(prog_ren && prog_addr == 16'd10) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (!(prog_ren && prog_addr == 16'd10)) begin
      n_err++;
      $display("FAIL scan_reach: got addr %h, expected scan at 000a", prog_addr);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++;
    if (prog_ren !== 1'b1 || prog_addr !== 16'h0000 || stdout !== 8'h00) begin
      n_err++;
      $display("FAIL scan_reset: got ren %b addr %h stdout %h, expected 1 0000 00",
               prog_ren, prog_addr, stdout);
    end
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h01);
    wait_halt(ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL scan_halt: got running, expected halt"); end
    check_common("scan", 3);
    n_cmp++;
    if (ram[0] !== 32'd2 || ram[1] !== 32'd1) begin
      n_err++;
      $display("FAIL scan_cells: got %h %h, expected 2 1", ram[0], ram[1]);
    end
    $display("reset-during-scan program done");
  endtask

  initial begin
    test_reset();
    test_add();
    test_loop();
    test_skip();
    test_wrap();
    test_stall();
    test_reset_scan();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
